// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: FSM state encodings and stream framing constants.
// Optional checksum trailer support is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHECK  = 3'd5
`endif
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and start-bit glitch rejection.
// Emits a one-cycle byte_valid or framing_err pulse when the stop bit is sampled.
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync1;
    logic            sync2;
    logic            prev;
    rx_state_t       rs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    // Bring the asynchronous line into the clock domain; prev feeds edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Bit-timing state machine: mid-bit sampling of start, data and stop bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs          <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            framing_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            unique case (rs)
                RX_IDLE: begin
                    if (prev && !sync2) begin
                        rs  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (sync2) begin
                            rs <= RX_IDLE;
                        end else begin
                            rs      <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shreg   <= {sync2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rs <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        rs  <= RX_IDLE;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rs <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: length-prefixed UART image -> little-endian imem word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic            byte_valid;
    logic [7:0]      byte_data;
    logic            framing_err;
    state_t          state;
    logic [1:0]      byte_cnt;
    logic [31:0]     packer;
    logic [ADDR_W:0] word_idx;
    logic [15:0]     hdr_n;
    logic [31:0]     next_word;
    logic            last_written;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      chk;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .framing_err(framing_err)
    );

    assign hdr_n        = {byte_data, word_count[7:0]};
    assign next_word    = {byte_data, packer[31:8]};
    assign last_written = imem_we && (16'(word_idx) == word_count);
    assign cpu_reset    = !done;

    // Loader FSM with byte packer, word index and optional running checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LEN_LO;
            byte_cnt   <= '0;
            packer     <= '0;
            word_idx   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (byte_valid && (state == S_LEN_LO || state == S_LEN_HI
                               || state == S_DATA)) begin
                chk <= chk ^ byte_data;
            end
`endif
            unique case (state)
                S_LEN_LO: begin
                    if (framing_err) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        word_count[7:0] <= byte_data;
                        busy            <= 1'b1;
                        state           <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (framing_err) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        word_count[15:8] <= byte_data;
                        if ({1'b0, hdr_n} > CAP) begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (framing_err) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (last_written) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= S_CHECK;
`else
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end else if (byte_valid) begin
                        packer   <= next_word;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= next_word;
                            imem_waddr <= {{(30 - ADDR_W){1'b0}},
                                           word_idx[ADDR_W-1:0], 2'b00};
                            word_idx   <= word_idx + 1'b1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (framing_err) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        busy <= 1'b0;
                        if (byte_data == chk) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE:  state <= S_DONE;
                S_ERROR: state <= S_ERROR;
                default: state <= S_ERROR;
            endcase
        end
    end

endmodule
